// File: rtl/painterengine_gpu_writer_arbiter.sv
// Shares one GPU DMA writer between 4 requesters: grant, reset/route/run, report.
// Ports: i_wire_req* from channels, o_wire_writer* to the writer, i_wire_writer* back from the writer, done/error pulses out.
// Optional: PAINTERENGINE_GPU_WRITER_ARB_PRIORITY_EN selects fixed priority (ch0 highest) instead of round-robin.
module painterengine_gpu_writer_arbiter #(
  parameter int PARAM_RESET_CYCLES  = 2,
  parameter int PARAM_WATCHDOG_BITS = 20
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  input  logic [3:0]   i_wire_req,
  input  logic [127:0] i_wire_req_address,
  input  logic [127:0] i_wire_req_length,
  input  logic [3:0]   i_wire_req_data_valid,
  output logic [3:0]   o_wire_req_data_next,
  output logic [3:0]   o_wire_req_done,
  output logic [3:0]   o_wire_req_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_busy,
  output logic         o_wire_writer_resetn,
  output logic [3:0]   o_wire_writer_router,
  output logic [127:0] o_wire_writer_address,
  output logic [127:0] o_wire_writer_length,
  output logic [3:0]   o_wire_writer_data_valid,
  input  logic [3:0]   i_wire_writer_data_next,
  input  logic         i_wire_writer_done,
  input  logic         i_wire_writer_error,
  input  logic [2:0]   i_wire_writer_error_type
);

  localparam int WB = PARAM_WATCHDOG_BITS;
  // Counter reaches all-ones on the edge that leaves this value.
  localparam logic [WB-1:0] WD_LAST = ~(WB'(1));
  localparam logic [3:0] ARM_LAST = 4'(PARAM_RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    REPORT
  } state_t;

  state_t         state;
  logic [3:0]     grant;
  logic [3:0]     router;
  logic [3:0]     done_q;
  logic [3:0]     err_q;
  logic [2:0]     etype;
  logic           wr_rstn;
  logic [127:0]   addr_q;
  logic [127:0]   len_q;
  logic [3:0]     arm_cnt;
  logic [WB-1:0]  wd;
  logic [3:0]     win;
  logic [127:0]   wmask;
  logic           run;

`ifdef PAINTERENGINE_GPU_WRITER_ARB_PRIORITY_EN
  always_comb begin
    win = '0;
    for (int i = 3; i >= 0; i--)
      if (i_wire_req[i]) win = 4'b1 << i;
  end
`else
  logic [1:0] ptr;
  logic [1:0] idx;
  logic       found;

  // Search starts just after the last winner.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && i_wire_req[idx]) begin
        win   = 4'b1 << idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    wmask = '0;
    for (int n = 0; n < 4; n++)
      wmask[n*32 +: 32] = {32{win[n]}};
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state   <= IDLE;
      grant   <= '0;
      router  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      etype   <= '0;
      wr_rstn <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      arm_cnt <= '0;
      wd      <= '0;
`ifndef PAINTERENGINE_GPU_WRITER_ARB_PRIORITY_EN
      ptr     <= 2'd3;
`endif
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state)
        IDLE: begin
          wr_rstn <= 1'b0;
          router  <= '0;
          if (|i_wire_req) begin
            grant   <= win;
            router  <= win;
            addr_q  <= i_wire_req_address & wmask;
            len_q   <= i_wire_req_length & wmask;
            arm_cnt <= '0;
            wd      <= '0;
`ifndef PAINTERENGINE_GPU_WRITER_ARB_PRIORITY_EN
            ptr     <= {win[3] | win[2], win[3] | win[1]};
`endif
            state   <= ARM;
          end
        end
        ARM: begin
          if (arm_cnt == ARM_LAST) begin
            wr_rstn <= 1'b1;
            state   <= RUN;
          end else begin
            arm_cnt <= arm_cnt + 4'd1;
          end
        end
        RUN: begin
          wd <= wd + 1'b1;
          if (i_wire_writer_error) begin
            etype <= i_wire_writer_error_type;
            err_q <= grant;
          end else if (i_wire_writer_done) begin
            done_q <= grant;
          end else if (wd == WD_LAST) begin
            etype <= 3'b101;
            err_q <= grant;
          end
          if (i_wire_writer_error || i_wire_writer_done
              || wd == WD_LAST) begin
            wr_rstn <= 1'b0;
            router  <= '0;
            state   <= REPORT;
          end
        end
        REPORT: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign run = (state == RUN);
  assign o_wire_busy              = (state != IDLE);
  assign o_wire_req_data_next     = i_wire_writer_data_next & grant & {4{run}};
  assign o_wire_writer_data_valid = i_wire_req_data_valid & grant & {4{run}};
  assign o_wire_req_done          = done_q;
  assign o_wire_req_error         = err_q;
  assign o_wire_error_type        = etype;
  assign o_wire_writer_resetn     = wr_rstn;
  assign o_wire_writer_router     = router;
  assign o_wire_writer_address    = addr_q;
  assign o_wire_writer_length     = len_q;

endmodule
